// File: rtl/bcp_pkg.sv
// Shared definitions for the BCP scheduling slice: FSM state encoding,
// default sizing and a constant-foldable clog2 helper.
package bcp_pkg;

    localparam int DEF_NUM_CLAUSES = 8;
    localparam int DEF_VAR_WIDTH   = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_SETTLE,
        S_SAMPLE,
        S_ISSUE,
        S_DONE,
        S_CONFLICT
    } bcp_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    localparam int DEF_IDX_WIDTH = clog2(DEF_NUM_CLAUSES);

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// scanning upward with wrap-around.
module rr_priority_pick
    import bcp_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_CLAUSES,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               any_o
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        grant_o = '0;
        idx     = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = int'(ptr_i) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_i[idx]) grant_o = IDX_W'(idx);
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/bcp_unit_scheduler.sv
// Sequences one BCP round over the unit-checker bank and issues implied
// literals to the trail one at a time with round-robin fairness.
module bcp_unit_scheduler
    import bcp_pkg::*;
#(
    parameter int NUM_CLAUSES = DEF_NUM_CLAUSES,
    parameter int VAR_WIDTH   = DEF_VAR_WIDTH,
    parameter int IDX_WIDTH   = clog2(NUM_CLAUSES)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    output logic                           en_part_sat,
    input  logic [NUM_CLAUSES-1:0]         unit_clause,
    input  logic [NUM_CLAUSES-1:0]         conflict_in,
    input  logic [NUM_CLAUSES*VAR_WIDTH-1:0] lit_var,
    input  logic [NUM_CLAUSES-1:0]         lit_pol,
    output logic                           imp_valid,
    input  logic                           imp_ready,
    output logic [VAR_WIDTH-1:0]           imp_var,
    output logic                           imp_pol,
    output logic [IDX_WIDTH-1:0]           imp_clause,
    output logic                           busy,
    output logic                           done,
    output logic                           conflict,
    output logic [IDX_WIDTH-1:0]           conflict_clause,
    output logic [VAR_WIDTH-1:0]           num_impl
);

    bcp_state_e               state_q, state_d;
    logic [NUM_CLAUSES-1:0]   served_q, served_d;
    logic [IDX_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
    logic                     imp_valid_q, imp_valid_d;
    logic [VAR_WIDTH-1:0]     imp_var_q, imp_var_d;
    logic                     imp_pol_q, imp_pol_d;
    logic [IDX_WIDTH-1:0]     imp_clause_q, imp_clause_d;
    logic                     done_q, done_d;
    logic                     conflict_q, conflict_d;
    logic [IDX_WIDTH-1:0]     cclause_q, cclause_d;
    logic [VAR_WIDTH-1:0]     num_impl_q, num_impl_d;
    logic                     en_q, en_d;
    logic                     busy_q, busy_d;

    logic [NUM_CLAUSES-1:0]   pending;
    logic [IDX_WIDTH-1:0]     grant;
    logic                     any_pending;
    logic [IDX_WIDTH-1:0]     conf_idx;

    assign pending = unit_clause & ~served_q;

    rr_priority_pick #(
        .NUM_REQ (NUM_CLAUSES),
        .IDX_W   (IDX_WIDTH)
    ) u_pick (
        .req_i   (pending),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .any_o   (any_pending)
    );

    always_comb begin
        conf_idx = '0;
        for (int i = NUM_CLAUSES - 1; i >= 0; i--) begin
            if (conflict_in[i]) conf_idx = IDX_WIDTH'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        served_d     = served_q;
        rr_ptr_d     = rr_ptr_q;
        imp_valid_d  = imp_valid_q;
        imp_var_d    = imp_var_q;
        imp_pol_d    = imp_pol_q;
        imp_clause_d = imp_clause_q;
        done_d       = 1'b0;
        conflict_d   = 1'b0;
        cclause_d    = cclause_q;
        num_impl_d   = num_impl_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_EVAL;
                    served_d   = '0;
                    num_impl_d = '0;
                    cclause_d  = '0;
                end
            end
            S_EVAL:   state_d = S_SETTLE;
            S_SETTLE: state_d = S_SAMPLE;
            S_SAMPLE: begin
                if (|conflict_in) begin
                    cclause_d  = conf_idx;
                    done_d     = 1'b1;
                    conflict_d = 1'b1;
                    state_d    = S_CONFLICT;
                end else if (!any_pending) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    imp_valid_d  = 1'b1;
                    imp_var_d    = lit_var[int'(grant)*VAR_WIDTH +: VAR_WIDTH];
                    imp_pol_d    = lit_pol[grant];
                    imp_clause_d = grant;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Re-evaluate after every accepted implication: the trail update
                // changes the checker counts.
                if (imp_ready) begin
                    served_d[imp_clause_q] = 1'b1;
                    if (imp_clause_q == IDX_WIDTH'(NUM_CLAUSES - 1)) rr_ptr_d = '0;
                    else rr_ptr_d = imp_clause_q + IDX_WIDTH'(1);
                    if (num_impl_q != '1) num_impl_d = num_impl_q + VAR_WIDTH'(1);
                    imp_valid_d = 1'b0;
                    state_d     = S_EVAL;
                end
            end
            S_DONE:     state_d = S_IDLE;
            S_CONFLICT: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        en_d   = (state_d == S_EVAL);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            served_q     <= '0;
            rr_ptr_q     <= '0;
            imp_valid_q  <= 1'b0;
            imp_var_q    <= '0;
            imp_pol_q    <= 1'b0;
            imp_clause_q <= '0;
            done_q       <= 1'b0;
            conflict_q   <= 1'b0;
            cclause_q    <= '0;
            num_impl_q   <= '0;
            en_q         <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            served_q     <= served_d;
            rr_ptr_q     <= rr_ptr_d;
            imp_valid_q  <= imp_valid_d;
            imp_var_q    <= imp_var_d;
            imp_pol_q    <= imp_pol_d;
            imp_clause_q <= imp_clause_d;
            done_q       <= done_d;
            conflict_q   <= conflict_d;
            cclause_q    <= cclause_d;
            num_impl_q   <= num_impl_d;
            en_q         <= en_d;
            busy_q       <= busy_d;
        end
    end

    assign en_part_sat     = en_q;
    assign imp_valid       = imp_valid_q;
    assign imp_var         = imp_var_q;
    assign imp_pol         = imp_pol_q;
    assign imp_clause      = imp_clause_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign conflict        = conflict_q;
    assign conflict_clause = cclause_q;
    assign num_impl        = num_impl_q;

endmodule

// File: tb/tb_bcp_unit_scheduler.sv
// Bench for bcp_unit_scheduler: table of BCP rounds with a scoreboard of
// expected implications, plus a hand-written asynchronous reset sequence.
module tb_bcp_unit_scheduler;

    localparam int N  = 8;
    localparam int VW = 8;
    localparam int IW = 3;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic            en_part_sat;
    logic [N-1:0]    unit_clause;
    logic [N-1:0]    conflict_in;
    logic [N*VW-1:0] lit_var;
    logic [N-1:0]    lit_pol;
    logic            imp_valid;
    logic            imp_ready;
    logic [VW-1:0]   imp_var;
    logic            imp_pol;
    logic [IW-1:0]   imp_clause;
    logic            busy;
    logic            done;
    logic            conflict;
    logic [IW-1:0]   conflict_clause;
    logic [VW-1:0]   num_impl;

    always #5 clock = ~clock;

    bcp_unit_scheduler dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .en_part_sat     (en_part_sat),
        .unit_clause     (unit_clause),
        .conflict_in     (conflict_in),
        .lit_var         (lit_var),
        .lit_pol         (lit_pol),
        .imp_valid       (imp_valid),
        .imp_ready       (imp_ready),
        .imp_var         (imp_var),
        .imp_pol         (imp_pol),
        .imp_clause      (imp_clause),
        .busy            (busy),
        .done            (done),
        .conflict        (conflict),
        .conflict_clause (conflict_clause),
        .num_impl        (num_impl)
    );

    typedef struct {
        logic [7:0] units;
        logic [7:0] pol;
        bit         drop;
        int         stall;
        logic [7:0] conf_after;
        logic [7:0] units_after;
        logic [7:0] exp_num;
        bit         exp_conf;
        logic [2:0] exp_cc;
    } vec_t;

    typedef struct {
        logic [7:0] v;
        logic       p;
        logic [2:0] c;
    } imp_t;

    imp_t sbq[$];
    int   rr_m;
    int   n_chk;
    int   n_pass;
    vec_t tbl[6];
    vec_t post;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic set_lits();
        for (int i = 0; i < N; i++) lit_var[i*VW +: VW] = VW'(i + 3);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_en"}, en_part_sat, 0);
        chk({tag, "_valid"}, imp_valid, 0);
        chk({tag, "_var"}, imp_var, 0);
        chk({tag, "_pol"}, imp_pol, 0);
        chk({tag, "_clause"}, imp_clause, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_conflict"}, conflict, 0);
        chk({tag, "_cclause"}, conflict_clause, 0);
        chk({tag, "_num"}, num_impl, 0);
    endtask

    // Transaction-level model of one round: pushes the expected implications.
    task automatic push_expected(input vec_t t);
        logic [7:0] u;
        logic [7:0] served;
        logic [7:0] cf;
        logic [7:0] pend;
        int         g;
        bit         first;
        u = t.units; served = '0; cf = '0; first = 1'b1;
        for (int k = 0; k < 64; k++) begin
            if (cf != 0) break;
            pend = u & ~served;
            if (pend == 0) break;
            g = 0;
            for (int o = N - 1; o >= 0; o--) begin
                int idx;
                idx = (rr_m + o) % N;
                if (pend[idx]) g = idx;
            end
            sbq.push_back('{v: 8'(g + 3), p: t.pol[g], c: 3'(g)});
            served[g] = 1'b1;
            rr_m = (g + 1) % N;
            if (t.drop) u[g] = 1'b0;
            if (first && t.conf_after != 0) begin
                u  = t.units_after;
                cf = t.conf_after;
            end
            first = 1'b0;
        end
    endtask

    task automatic run_round(input vec_t t);
        int   since;
        int   cnt;
        bit   in_imp;
        bit   fin;
        bit   conf_applied;
        imp_t cur;
        unit_clause = t.units;
        lit_pol     = t.pol;
        conflict_in = '0;
        set_lits();
        imp_ready   = (t.stall == 0);
        push_expected(t);
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        since = 0; cnt = 0; in_imp = 0; fin = 0; conf_applied = 0;
        cur = '{v: '0, p: 1'b0, c: '0};
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            if (cyc > 0) begin
                @(negedge clock);
                since++;
            end
            if (imp_valid) begin
                if (!in_imp) begin
                    in_imp = 1; cnt = 0;
                    chk("imp_latency", since, 3);
                    if (sbq.size() == 0) begin
                        chk("unexpected_imp", 1, 0);
                        cur = '{v: imp_var, p: imp_pol, c: imp_clause};
                    end else begin
                        cur = sbq.pop_front();
                        chk("imp_var", imp_var, cur.v);
                        chk("imp_pol", imp_pol, cur.p);
                        chk("imp_clause", imp_clause, cur.c);
                    end
                end else begin
                    chk("hold_var", imp_var, cur.v);
                    chk("hold_pol", imp_pol, cur.p);
                    chk("hold_clause", imp_clause, cur.c);
                end
                if (cnt < t.stall) begin
                    imp_ready = 1'b0;
                    if (cnt == 2) start = 1'b1;
                    if (cnt == 3) begin
                        start   = 1'b0;
                        lit_var = ~lit_var;
                    end
                    cnt++;
                end else begin
                    imp_ready = 1'b1;
                    start     = 1'b0;
                    set_lits();
                    if (t.drop) unit_clause[cur.c] = 1'b0;
                    if (t.conf_after != 0 && !conf_applied) begin
                        unit_clause  = t.units_after;
                        conflict_in  = t.conf_after;
                        conf_applied = 1;
                    end
                    since  = -1;
                    in_imp = 0;
                end
            end else if (done) begin
                chk("done_latency", since, 3);
                chk("conflict_flag", conflict, t.exp_conf);
                chk("num_impl", num_impl, t.exp_num);
                chk("conflict_clause", conflict_clause, t.exp_cc);
                chk("sb_empty", sbq.size(), 0);
                fin = 1;
            end else begin
                if (since == 0) chk("en_high", en_part_sat, 1);
                if (since == 1) chk("en_low", en_part_sat, 0);
                chk("busy_in_round", busy, 1);
                if (t.stall > 0) imp_ready = 1'b0;
            end
        end
        if (!fin) chk("round_timeout", 0, 1);
        @(negedge clock);
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_conflict", conflict, 0);
        chk("post_cclause_held", conflict_clause, t.exp_cc);
        chk("post_num_held", num_impl, t.exp_num);
        sbq.delete();
        unit_clause = '0;
        conflict_in = '0;
        imp_ready   = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; rr_m = 0;
        reset = 1'b1; start = 1'b0; imp_ready = 1'b0;
        unit_clause = '0; conflict_in = '0; lit_pol = '0;
        set_lits();

        tbl[0] = '{units: 8'h00, pol: 8'h00, drop: 0, stall: 0, conf_after: 8'h00, units_after: 8'h00, exp_num: 8'd0, exp_conf: 0, exp_cc: 3'd0};
        tbl[1] = '{units: 8'h04, pol: 8'h04, drop: 1, stall: 0, conf_after: 8'h00, units_after: 8'h00, exp_num: 8'd1, exp_conf: 0, exp_cc: 3'd0};
        tbl[2] = '{units: 8'h04, pol: 8'h04, drop: 1, stall: 6, conf_after: 8'h00, units_after: 8'h00, exp_num: 8'd1, exp_conf: 0, exp_cc: 3'd0};
        tbl[3] = '{units: 8'h82, pol: 8'h80, drop: 0, stall: 0, conf_after: 8'h00, units_after: 8'h00, exp_num: 8'd2, exp_conf: 0, exp_cc: 3'd0};
        tbl[4] = '{units: 8'h69, pol: 8'hAA, drop: 1, stall: 1, conf_after: 8'h00, units_after: 8'h00, exp_num: 8'd4, exp_conf: 0, exp_cc: 3'd0};
        tbl[5] = '{units: 8'h02, pol: 8'h02, drop: 0, stall: 0, conf_after: 8'h30, units_after: 8'h01, exp_num: 8'd1, exp_conf: 1, exp_cc: 3'd4};
        post   = '{units: 8'h81, pol: 8'h01, drop: 0, stall: 2, conf_after: 8'h00, units_after: 8'h00, exp_num: 8'd2, exp_conf: 0, exp_cc: 3'd0};

        #1;
        check_all_zero("reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 6; i++) run_round(tbl[i]);

        // Asynchronous reset while an implication is being offered.
        unit_clause = 8'h10; lit_pol = 8'h10; imp_ready = 1'b0;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        for (int i = 0; i < 20 && !imp_valid; i++) @(negedge clock);
        chk("rst_pre_valid", imp_valid, 1);
        #2 reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clock);
        reset = 1'b0;
        unit_clause = '0;
        rr_m = 0;
        @(negedge clock);
        run_round(post);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bcp_unit_scheduler.md
Name: bcp_unit_scheduler

Overview:
- Sequences one Boolean-constraint-propagation round over a bank of NUM_CLAUSES clocked unit checkers.
- Pulses their en_part_sat enable and collects the unit_clause and conflict flags.
- Issues one implied literal at a time to the trail/assignment unit over a valid/ready handshake, with round-robin fairness.
- Sits between the decision logic (start) and the trail, and drives the unit-checker bank.

Parameters:
- NUM_CLAUSES, 8, number of clause/unit-checker slots.
- VAR_WIDTH, 8, width of a variable index (matches checker size).
- IDX_WIDTH, 3, clog2(NUM_CLAUSES), width of a clause index.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: begin a BCP round; ignored unless state is IDLE.
- en_part_sat  out  1  enable to all unit checkers; high only in state EVAL.
- unit_clause  in  NUM_CLAUSES  per-clause registered unit flag from the checkers.
- conflict_in  in  NUM_CLAUSES  per-clause "all literals false" flag.
- lit_var  in  NUM_CLAUSES*VAR_WIDTH  per-clause unassigned literal variable; slot i is bits [i*VAR_WIDTH +: VAR_WIDTH].
- lit_pol  in  NUM_CLAUSES  per-clause polarity of that literal.
- imp_valid  out  1  implication available.
- imp_ready  in  1  trail accepts the implication.
- imp_var  out  VAR_WIDTH  implied variable.
- imp_pol  out  1  implied polarity.
- imp_clause  out  IDX_WIDTH  index of the reason clause.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a round.
- conflict  out  1  one-cycle pulse with done when the round ends in conflict.
- conflict_clause  out  IDX_WIDTH  lowest conflicting clause index; held until the next accepted start.
- num_impl  out  VAR_WIDTH  implications issued this round; saturates at all-ones; held until the next start.

Behaviour:
- Reset (asynchronous, any time, including mid-round): state=IDLE. All outputs are 0: en_part_sat, imp_valid, imp_var, imp_pol, imp_clause, busy, done, conflict, conflict_clause, num_impl. Internal served_mask=0 and rr_ptr=0.
- All outputs are registered.
- State IDLE: start=1 -> EVAL. On this transition: served_mask=0, num_impl=0, conflict_clause=0. rr_ptr is retained across rounds.
- State EVAL: en_part_sat=1 for exactly one cycle -> SETTLE.
- State SETTLE: one-cycle wait for the checker register -> SAMPLE.
- State SAMPLE: evaluated in priority order.
  - If conflict_in != 0: conflict_clause = lowest set index -> CONFLICT.
  - Else pending = unit_clause & ~served_mask. If pending == 0 -> DONE.
  - Else grant = first set bit of pending at or after rr_ptr, scanning upward with wrap-around. Load imp_var, imp_pol and imp_clause from slot grant. Set imp_valid=1 -> ISSUE.
- State ISSUE: imp_valid, imp_var, imp_pol and imp_clause are held stable until imp_ready=1 is sampled. On handshake:
  - served_mask[grant]=1.
  - rr_ptr = (grant+1) mod NUM_CLAUSES.
  - num_impl increments, saturating.
  - imp_valid=0 -> EVAL, re-evaluating because the new assignment changes the checker counts.
- State DONE: done=1 for one cycle -> IDLE.
- State CONFLICT: done=1 and conflict=1 for one cycle -> IDLE.
- Latency, with start sampled at edge 0:
  - en_part_sat is high after edge 0.
  - imp_valid or done is high after edge 3.
  - After a handshake at edge k, the next imp_valid or done appears after edge k+3.
- Conflict has priority over pending units in the same SAMPLE cycle.
- Inputs are sampled only in SAMPLE. Changes to unit_clause, conflict_in or lit_* during ISSUE have no effect on the outputs being held.
- A served clause whose unit_clause stays high is never reissued within the round.
- imp_ready asserted outside ISSUE is ignored.
- start during busy is ignored.

Decomposition:
- Shared package bcp_pkg holds:
  - the state encoding (IDLE, EVAL, SETTLE, SAMPLE, ISSUE, DONE, CONFLICT);
  - the defaults NUM_CLAUSES, VAR_WIDTH and IDX_WIDTH;
  - a clog2 function.
- One sub-module: rr_priority_pick. It is combinational and takes (req[NUM_CLAUSES], ptr) and returns grant index and any_req. It is reused by future requester arbiters.

Test Plan:
- Round with no units: start, unit_clause=0, conflict_in=0 -> en_part_sat high one cycle after edge 0; done=1 after edge 3; conflict=0; num_impl=0; busy falls with return to IDLE.
- Single unit: unit_clause=8'b0000_0100, lit_var[2]=8'd5, lit_pol[2]=1, imp_ready tied 1 -> one implication with imp_var=5, imp_pol=1, imp_clause=2. Checker then drops the bit -> done, num_impl=1.
- Backpressure: same as the single-unit case but imp_ready=0 for 6 cycles -> imp_valid and its payload held constant all 6 cycles; handshake on the 7th; exactly one implication.
- Round-robin: rr_ptr=3 left from the previous round, unit_clause=8'b1000_0010 held high -> issue order clause 7 then clause 1; then done with num_impl=2 and no reissue.
- Conflict: after the first implication the checker raises conflict_in=8'b0011_0000 together with unit_clause=8'b0000_0001 -> done=1 and conflict=1 in the same cycle; conflict_clause=4; no further imp_valid.
- Reset mid-ISSUE: reset asserted asynchronously while imp_valid=1 -> all outputs 0 immediately with no clock edge; state IDLE; the next start behaves as a fresh round with rr_ptr=0.
